// File: rtl/gs_div_pkg.sv
// gs_div_pkg: shared definitions for the Goldschmidt integer divider.
//   - gs_state_e : controller state encoding
//   - gs_dw()    : iteration datapath width (W integer + FW fraction + 2 guard bits)
//   - gs_two()   : the constant 2.0 in that datapath format
//   - gs_fw_ok() / gs_iter_ok() : parameter legality checks used at elaboration
//   - lzc()      : leading-zero count over the low w bits of a 64-bit vector
package gs_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NORM = 3'd1,
    ST_SEED = 3'd2,
    ST_ITER = 3'd3,
    ST_CORR = 3'd4,
    ST_DONE = 3'd5
  } gs_state_e;

  localparam int GS_DEF_W        = 32;
  localparam int GS_DEF_FW       = 36;
  localparam int GS_DEF_LUT_BITS = 8;
  localparam int GS_DEF_ITER     = 3;
  localparam int GS_DEF_DW       = GS_DEF_W + GS_DEF_FW + 2;

  function automatic int gs_dw(input int w, input int fw);
    return w + fw + 2;
  endfunction

  // 2.0 with fw fraction bits; only meaningful for fw <= 125.
  function automatic logic [127:0] gs_two(input int fw);
    return 128'd2 << fw;
  endfunction

  function automatic bit gs_fw_ok(input int w, input int fw);
    return fw >= w + 2;
  endfunction

  // Seed precision doubles each pass, so LUT_BITS*2^ITER must cover W+2 bits.
  function automatic bit gs_iter_ok(input int w, input int lut_bits, input int iter);
    return (lut_bits << iter) >= (w + 2);
  endfunction

  function automatic logic [6:0] lzc(input logic [63:0] v, input int w);
    logic [6:0] cnt;
    logic       hit;
    cnt = 7'd0;
    hit = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (i < w && !hit) begin
        if (v[i]) begin
          hit = 1'b1;
        end else begin
          cnt = cnt + 7'd1;
        end
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gs_div_param_seed_rom.sv
// gs_seed_rom: reciprocal seed table for the Goldschmidt divider.
// The normalised divisor lies in [0.5,1); its LUT_BITS bits below the MSB select
// one of 2^LUT_BITS equal sub-intervals. Each entry is round(1/midpoint) with FW
// fraction bits (value in (1,2), FW+2 bits wide). The table is constant and is
// built at elaboration from the parameters.
//   idx : interval index (normalised divisor bits below the leading one)
//   f   : seed reciprocal F0
module gs_seed_rom
  import gs_div_pkg::*;
#(
  parameter int LUT_BITS = 8,
  parameter int FW       = 36
) (
  input  logic [LUT_BITS-1:0] idx,
  output logic [FW+1:0]       f
);

  localparam int ENTRIES = 1 << LUT_BITS;
  localparam int NW      = FW + LUT_BITS + 4;

  // midpoint = (2^(LB+1) + 2i + 1) / 2^(LB+2); reciprocal scaled by 2^FW, rounded.
  function automatic logic [FW+1:0] recip_mid(input int unsigned i);
    logic [NW-1:0] num;
    logic [NW-1:0] den;
    num = '0;
    num[FW+LUT_BITS+2] = 1'b1;
    den = (NW'(i) << 1) + NW'(1'b1);
    den[LUT_BITS+1] = 1'b1;
    return (FW+2)'((num + (den >> 1)) / den);
  endfunction

  logic [FW+1:0] rom_s [ENTRIES];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_rom
    localparam logic [FW+1:0] ENTRY = recip_mid(i);
    assign rom_s[i] = ENTRY;
  end

  assign f = rom_s[idx];

endmodule

// File: rtl/gs_div_param.sv
// gs_div_param: parameterised Goldschmidt integer divider with valid/ready
// handshakes. Returns quotient q and remainder r; dbz flags divide-by-zero.
// Trivial cases (d==0, n<d, d==1) finish one cycle after accept; all others take
// ITER+3 cycles: NORM, SEED, ITER-1 refinement passes, CORR, then DONE.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   n, d                : dividend, divisor (W bits)
//   out_valid/out_ready : result handshake; q/r/dbz held until popped
//   q, r, dbz           : quotient, remainder, divide-by-zero flag
//   is_signed           : only with GS_DIV_SIGNED_EN; selects signed operands
// Build option GS_DIV_SIGNED_EN adds signed division (truncate toward zero,
// remainder carries the dividend sign) with no extra latency.
module gs_div_param
  import gs_div_pkg::*;
#(
  parameter int W        = 32,
  parameter int FW       = 36,
  parameter int LUT_BITS = 8,
  parameter int ITER     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] n,
  input  logic [W-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dbz
`ifdef GS_DIV_SIGNED_EN
  ,
  input  logic         is_signed
`endif
);

  localparam int DW   = gs_dw(W, FW);
  localparam int FWID = FW + 2;
  localparam int MW   = DW + FWID;
  localparam logic [DW-1:0] TWO = DW'(gs_two(FW));

  if (!gs_fw_ok(W, FW)) begin : g_bad_fw
    $error("gs_div_param: FW must be at least W+2");
  end
  if (!gs_iter_ok(W, LUT_BITS, ITER)) begin : g_bad_iter
    $error("gs_div_param: LUT_BITS*2^ITER must be at least W+2");
  end

  gs_state_e         state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      q_q, q_d, r_q, r_d;
  logic              dbz_q, dbz_d;
  logic [W-1:0]      num_q, num_d, den_q, den_d;
  logic [DW-1:0]     nx_q, nx_d, dx_q, dx_d;
  logic [7:0]        cnt_q, cnt_d;
`ifdef GS_DIV_SIGNED_EN
  logic              nneg_q, nneg_d, qneg_q, qneg_d;
  logic              n_neg_s, d_neg_s;

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic neg);
    if (neg) begin
      return ~v + W'(1'b1);
    end else begin
      return v;
    end
  endfunction
`endif

  logic [W-1:0]      na_s, da_s;
  logic [6:0]        s_s;
  logic [W-1:0]      dn_s;
  logic [FWID-1:0]   seed_s, f_s;
  logic [DW-1:0]     nmul_s, dmul_s;
  logic [W-1:0]      qe_s, qc_s, rc_s;
  logic [W:0]        re_s;

  gs_seed_rom #(
    .LUT_BITS (LUT_BITS),
    .FW       (FW)
  ) u_seed_rom (
    .idx (dx_q[FW-2 -: LUT_BITS]),
    .f   (seed_s)
  );

  // Datapath helpers: operand magnitudes, normalisation, multiplier pair, correction.
  always_comb begin
`ifdef GS_DIV_SIGNED_EN
    n_neg_s = is_signed & n[W-1];
    d_neg_s = is_signed & d[W-1];
    na_s    = neg_if(n, n_neg_s);
    da_s    = neg_if(d, d_neg_s);
`else
    na_s    = n;
    da_s    = d;
`endif
    s_s  = lzc(64'(den_q), W);
    dn_s = den_q << s_s;
    // SEED multiplies by the table entry, ITER by 2-D (always positive, < 2).
    if (state_q == ST_SEED) begin
      f_s = seed_s;
    end else begin
      f_s = FWID'(TWO - dx_q);
    end
    nmul_s = DW'((MW'(nx_q) * MW'(f_s)) >> FW);
    dmul_s = DW'((MW'(dx_q) * MW'(f_s)) >> FW);
    // floor(N) is within one of the true quotient; W+1 bits hold n - qe*d exactly.
    qe_s = nx_q[FW +: W];
    re_s = {1'b0, num_q} - ((W+1)'(qe_s) * (W+1)'(den_q));
    if (re_s[W]) begin
      qc_s = qe_s - W'(1'b1);
      rc_s = re_s[W-1:0] + den_q;
    end else if (re_s >= {1'b0, den_q}) begin
      qc_s = qe_s + W'(1'b1);
      rc_s = re_s[W-1:0] - den_q;
    end else begin
      qc_s = qe_s;
      rc_s = re_s[W-1:0];
    end
  end

  // Controller next-state and register updates.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    q_d         = q_q;
    r_d         = r_q;
    dbz_d       = dbz_q;
    num_d       = num_q;
    den_d       = den_q;
    nx_d        = nx_q;
    dx_d        = dx_q;
    cnt_d       = cnt_q;
`ifdef GS_DIV_SIGNED_EN
    nneg_d      = nneg_q;
    qneg_d      = qneg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (da_s == '0) begin
            q_d = '1;
            r_d = n;
            dbz_d = 1'b1;
            out_valid_d = 1'b1;
            state_d = ST_DONE;
          end else if (na_s < da_s) begin
            // Remainder is the dividend itself, sign included.
            q_d = '0;
            r_d = n;
            dbz_d = 1'b0;
            out_valid_d = 1'b1;
            state_d = ST_DONE;
          end else if (da_s == W'(1'b1)) begin
`ifdef GS_DIV_SIGNED_EN
            q_d = neg_if(na_s, n_neg_s ^ d_neg_s);
`else
            q_d = na_s;
`endif
            r_d = '0;
            dbz_d = 1'b0;
            out_valid_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            num_d = na_s;
            den_d = da_s;
`ifdef GS_DIV_SIGNED_EN
            nneg_d = n_neg_s;
            qneg_d = n_neg_s ^ d_neg_s;
`endif
            state_d = ST_NORM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NORM: begin
        // Divisor to [0.5,1); dividend scaled identically so the ratio is unchanged.
        dx_d = DW'(dn_s) << (FW - W);
        nx_d = DW'(num_q) << (FW - W + int'(s_s));
        state_d = ST_SEED;
      end
      ST_SEED: begin
        nx_d = nmul_s;
        dx_d = dmul_s;
        cnt_d = 8'd0;
        if (ITER > 1) begin
          state_d = ST_ITER;
        end else begin
          state_d = ST_CORR;
        end
      end
      ST_ITER: begin
        nx_d = nmul_s;
        dx_d = dmul_s;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(ITER - 2)) begin
          state_d = ST_CORR;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_CORR: begin
`ifdef GS_DIV_SIGNED_EN
        q_d = neg_if(qc_s, qneg_q);
        r_d = neg_if(rc_s, nneg_q);
`else
        q_d = qc_s;
        r_d = rc_s;
`endif
        dbz_d = 1'b0;
        out_valid_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation or held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      dbz_q       <= 1'b0;
      num_q       <= '0;
      den_q       <= '0;
      nx_q        <= '0;
      dx_q        <= '0;
      cnt_q       <= 8'd0;
`ifdef GS_DIV_SIGNED_EN
      nneg_q      <= 1'b0;
      qneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      r_q         <= r_d;
      dbz_q       <= dbz_d;
      num_q       <= num_d;
      den_q       <= den_d;
      nx_q        <= nx_d;
      dx_q        <= dx_d;
      cnt_q       <= cnt_d;
`ifdef GS_DIV_SIGNED_EN
      nneg_q      <= nneg_d;
      qneg_q      <= qneg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_gs_div_param.sv
// tb_gs_div_param: directed self-checking bench for gs_div_param (default
// parameters). Inputs change and outputs are sampled 1 time unit after the
// rising clock edge.
module tb_gs_div_param;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] n_i;
  logic [W-1:0] d_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dbz;
`ifdef GS_DIV_SIGNED_EN
  logic         sgn_mode = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  gs_div_param #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n_i),
    .d         (d_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dbz       (dbz)
`ifdef GS_DIV_SIGNED_EN
    ,
    .is_signed (sgn_mode)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what,
                     input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, measure latency, check the result, then pop it.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edbz, input int elat);
    int lat;
    chk(tag, "in_ready_idle", 64'(in_ready), 64'd1);
    n_i = a;
    d_i = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk(tag, "latency", 64'(lat), 64'(elat));
    chk(tag, "q", 64'(q), 64'(eq));
    chk(tag, "r", 64'(r), 64'(er));
    chk(tag, "dbz", 64'(dbz), 64'(edbz));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk(tag, "out_valid_pop", 64'(out_valid), 64'd0);
    chk(tag, "in_ready_pop", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_i = '0;
    d_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset", "in_ready", 64'(in_ready), 64'd1);
    chk("reset", "out_valid", 64'(out_valid), 64'd0);
    chk("reset", "q", 64'(q), 64'd0);
    chk("reset", "r", 64'(r), 64'd0);
    chk("reset", "dbz", 64'(dbz), 64'd0);

    // Directed vectors, hand-computed.
    do_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 6);
    do_op("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    do_op("3/10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1);
    do_op("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    do_op("max/max-1", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 6);
    do_op("max/ffff", 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 1'b0, 6);
    do_op("2^31/3", 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0, 6);
    do_op("eq", 32'd12345678, 32'd12345678, 32'd1, 32'd0, 1'b0, 6);
    do_op("0/0", 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
    do_op("big/1000", 32'd1000000007, 32'd1000, 32'd1000000, 32'd7, 1'b0, 6);
    do_op("max/2^31+1", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 6);
    do_op("2/2", 32'd2, 32'd2, 32'd1, 32'd0, 1'b0, 6);

    // Backpressure: result held for 10 cycles, new operands ignored until popped.
    n_i = 32'd100;
    d_i = 32'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp", "latency", 64'(lat), 64'd6);
    n_i = 32'd9;
    d_i = 32'd3;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp", "q_hold", 64'(q), 64'd14);
      chk("bp", "r_hold", 64'(r), 64'd2);
      chk("bp", "dbz_hold", 64'(dbz), 64'd0);
      chk("bp", "out_valid_hold", 64'(out_valid), 64'd1);
      chk("bp", "in_ready_hold", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp", "out_valid_pop", 64'(out_valid), 64'd0);
    chk("bp", "in_ready_pop", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp", "accepted_next", 64'(in_ready), 64'd0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp9/3", "latency", 64'(lat), 64'd6);
    chk("bp9/3", "q", 64'(q), 64'd3);
    chk("bp9/3", "r", 64'(r), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while iterating: everything returns to the idle/reset state.
    do_op("5/2", 32'd5, 32'd2, 32'd2, 32'd1, 1'b0, 6);
    n_i = 32'd100;
    d_i = 32'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_iter", "in_ready", 64'(in_ready), 64'd1);
    chk("rst_iter", "out_valid", 64'(out_valid), 64'd0);
    chk("rst_iter", "q", 64'(q), 64'd0);
    chk("rst_iter", "r", 64'(r), 64'd0);
    chk("rst_iter", "dbz", 64'(dbz), 64'd0);
    do_op("81/9", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 6);

`ifdef GS_DIV_SIGNED_EN
    sgn_mode = 1'b1;
    do_op("s-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 6);
    do_op("s7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 6);
    do_op("smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1);
    do_op("s-7/0", 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1);
    sgn_mode = 1'b0;
`endif

    // Random operands against the language's own / and % operators.
    for (int k = 0; k < 200; k++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (k % 16 == 0) begin
        b = 32'd0;
      end else if (k % 16 == 1) begin
        b = 32'd1;
      end else begin
        b = b;
      end
      do_op("rand", a, b,
            (b == 32'd0) ? 32'hFFFF_FFFF : a / b,
            (b == 32'd0) ? a : a % b,
            (b == 32'd0),
            (b == 32'd0 || a < b || b == 32'd1) ? 1 : 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/gs_div_param.md
Name: gs_div_param

Overview:
- Parameterised Goldschmidt integer divider, successor to the fixed 64-bit datapath divider.
- Returns quotient and remainder, with valid/ready handshakes on both input and output.
- Adds leading-zero normalisation, a table seed, a fixed iteration count set by parameter, exact ±1 correction and a divide-by-zero flag.
- Sits between the operand staging registers and the result writeback stage of the arithmetic unit.

Parameters:
W, 32, operand/quotient/remainder width in bits (8..64)
FW, 36, internal fraction bits of the iteration datapath; must be ≥ W+2 (elaboration error otherwise)
LUT_BITS, 8, divisor index bits into the reciprocal seed ROM
ITER, 3, Goldschmidt iterations; must satisfy LUT_BITS·2^ITER ≥ W+2 (elaboration error otherwise)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands presented
in_ready  out  1  block can accept operands
n  in  W  dividend
d  in  W  divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
q  out  W  quotient
r  out  W  remainder
dbz  out  1  divide-by-zero flag, qualified by out_valid
(is_signed  in  1  present only with GS_DIV_SIGNED_EN)

Behaviour:
- Reset, sampled on a clk edge:
  - state=IDLE; in_ready=1; out_valid=0; q=0; r=0; dbz=0.
  - rst dominates every state and abandons any in-flight operation or held result.
- Handshake:
  - Accept when in_valid&&in_ready. in_ready=1 only in IDLE.
  - Result is held stable from the rising of out_valid until out_valid&&out_ready.
  - On that cycle: IDLE, in_ready=1 next cycle. No same-cycle accept-after-pop.
- States: IDLE, NORM, SEED, ITER, CORR, DONE.
  - IDLE->DONE (fast path, out_valid on the cycle after accept) when:
    - d==0: q=all ones, r=n, dbz=1.
    - n<d: q=0, r=n.
    - d==1: q=n, r=0.
  - IDLE->NORM otherwise.
  - NORM: s=lzc(d); Dn=d<<s, with MSB set, treated as value in [0.5,1). N0=(n<<s) as fixed point with W integer and FW fraction bits (value n·2^s/2^W).
  - SEED: F0 = ROM[Dn[W-2 -: LUT_BITS]], approximating 1/Dn. N1=N0·F0, D1=Dn·F0, truncated to FW fraction bits.
  - ITER: one iteration per cycle on a single multiplier pair. Fi=2−Di (two's complement in datapath width). N←N·Fi, D←D·Fi, truncated. Runs ITER−1 cycles, then CORR.
  - CORR:
    - qe=floor(N); re=n−qe·d, computed in W+1 signed bits.
    - re<0 → q=qe−1, r=re+d.
    - re≥d → q=qe+1, r=re−d.
    - else q=qe, r=re.
    - Error of qe is guaranteed ≤1 by the parameter constraints.
  - DONE: out_valid=1; wait for out_ready.
- Latency, accept to out_valid: fast path 1 cycle; normal path ITER+3 cycles (6 at defaults). Fixed and data-independent.
- Quotient never overflows W bits in unsigned mode.

Optional Feature:
GS_DIV_SIGNED_EN
- Defined:
  - Adds is_signed, sampled at accept.
  - Signed mode converts operands to magnitude, divides unsigned, then restores signs in DONE entry with no added latency.
  - Truncates toward zero; remainder takes the dividend's sign.
  - MIN/−1 → q=MIN, r=0, dbz=0.
  - d==0 → q=all ones, r=n, dbz=1.
  - The n<d and d==1 fast paths compare magnitudes.
- Undefined: is_signed absent; unsigned only. Area carries no negation logic.

Decomposition:
- gs_div_pkg:
  - State enum.
  - Localparams for datapath width (W+FW+2) and constant TWO in that format.
  - lzc function.
  - Elaboration checks on FW and ITER.
- Sub-module gs_seed_rom (LUT_BITS→FW+2 bit reciprocal table, combinational, generated from parameters). Each entry is the rounded reciprocal of the interval midpoint.
- Multiplier pair and correction logic stay inline.

Test Plan:
- n=100, d=7 (defaults) → q=14, r=2, dbz=0, out_valid exactly 6 cycles after accept.
- n=5, d=0 → q=0xFFFFFFFF, r=5, dbz=1, out_valid 1 cycle after accept. Then n=3, d=10 → q=0, r=3 in 1 cycle.
- n=0xFFFFFFFF, d=1 and n=0xFFFFFFFF, d=0xFFFFFFFE → q=0xFFFFFFFF, r=0 and q=1, r=1. Plus 10^5 random pairs vs. a reference model, zero mismatches.
- Backpressure: out_ready=0 for 10 cycles after out_valid → q/r/dbz stable, in_ready=0, new in_valid ignored. Pop, then accept the next op the cycle after.
- rst asserted in ITER → next cycle IDLE, out_valid=0, in_ready=1, q=r=0. Following op 81/9 → q=9, r=0.
- GS_DIV_SIGNED_EN: −7/2 → q=−3, r=−1. 7/−2 → q=−3, r=1. 0x80000000/−1 → q=0x80000000, r=0.
